// File: rtl/input_conditioner_bank.sv
// Bank of independent input conditioners: two-flop synchronizer, counter-based
// debounce, registered edge pulses and sticky edge-seen flags per channel.
module input_conditioner_bank #(
  parameter int   CHANNELS     = 4,
  parameter int   WAITTIME     = 3,
  parameter int   COUNTERWIDTH = 3,
  parameter logic INIT_LEVEL   = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] noisysignal,
  input  logic [CHANNELS-1:0] enable,
  input  logic [CHANNELS-1:0] clearflags,
  output logic [CHANNELS-1:0] conditioned,
  output logic [CHANNELS-1:0] positiveedge,
  output logic [CHANNELS-1:0] negativeedge,
  output logic [CHANNELS-1:0] edgeflag,
  output logic                anyedge
);

  localparam logic [COUNTERWIDTH-1:0] LAST_COUNT = COUNTERWIDTH'(WAITTIME - 1);
  localparam logic [CHANNELS-1:0]     INIT_VEC   = {CHANNELS{INIT_LEVEL}};

  logic [CHANNELS-1:0]     sync0_q, sync1_q;
  logic [CHANNELS-1:0]     cond_q, cond_d;
  logic [CHANNELS-1:0]     pos_q, pos_d;
  logic [CHANNELS-1:0]     neg_q, neg_d;
  logic [CHANNELS-1:0]     flag_q, flag_d;
  logic [CHANNELS-1:0]     fire;
  logic [COUNTERWIDTH-1:0] cnt_q [CHANNELS];
  logic [COUNTERWIDTH-1:0] cnt_d [CHANNELS];

  // Debounce decision per channel; priority: enable, agreement, terminal count.
  always_comb begin
    cond_d = cond_q;
    fire   = '0;
    cnt_d  = cnt_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!enable[i]) begin
        cnt_d[i] = '0;
      end else if (sync1_q[i] == cond_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == LAST_COUNT) begin
        cond_d[i] = sync1_q[i];
        cnt_d[i]  = '0;
        fire[i]   = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    pos_d  = fire & sync1_q;
    neg_d  = fire & ~sync1_q;
    // A new pulse overrides a coincident clear request.
    flag_d = fire | (flag_q & ~clearflags);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0_q <= INIT_VEC;
      sync1_q <= INIT_VEC;
      cond_q  <= INIT_VEC;
      pos_q   <= '0;
      neg_q   <= '0;
      flag_q  <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync0_q <= noisysignal;
      sync1_q <= sync0_q;
      cond_q  <= cond_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
      flag_q  <= flag_d;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign conditioned  = cond_q;
  assign positiveedge = pos_q;
  assign negativeedge = neg_q;
  assign edgeflag     = flag_q;
  assign anyedge      = |(pos_q | neg_q);

endmodule

// File: tb/tb_input_conditioner_bank.sv
// Self-checking bench for input_conditioner_bank: a reference model feeds an
// expected queue each cycle, plus directed latency/glitch/flag/enable/reset checks.
module tb_input_conditioner_bank;

  localparam int CH = 4;
  localparam int WT = 3;
  localparam int CW = 3;
  localparam int EW = 4 * CH + 1;

  logic          clk;
  logic          rst_n;
  logic [CH-1:0] noisysignal, enable, clearflags;
  logic [CH-1:0] conditioned, positiveedge, negativeedge, edgeflag;
  logic          anyedge;

  logic [1:0]    ns1, en1, clr1;
  logic [1:0]    cond1, pos1, neg1, flag1;
  logic          any1;

  int n_cmp;
  int n_err;

  logic [EW-1:0] exp_q[$];

  logic [CH-1:0] m_s0, m_s1, m_cond, m_flag;
  int            m_cnt [CH];

  input_conditioner_bank #(
    .CHANNELS(CH), .WAITTIME(WT), .COUNTERWIDTH(CW), .INIT_LEVEL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .noisysignal(noisysignal), .enable(enable), .clearflags(clearflags),
    .conditioned(conditioned), .positiveedge(positiveedge),
    .negativeedge(negativeedge), .edgeflag(edgeflag), .anyedge(anyedge)
  );

  input_conditioner_bank #(
    .CHANNELS(2), .WAITTIME(WT), .COUNTERWIDTH(CW), .INIT_LEVEL(1'b1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n),
    .noisysignal(ns1), .enable(en1), .clearflags(clr1),
    .conditioned(cond1), .positiveedge(pos1),
    .negativeedge(neg1), .edgeflag(flag1), .anyedge(any1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s0   = '0;
    m_s1   = '0;
    m_cond = '0;
    m_flag = '0;
    for (int i = 0; i < CH; i++) m_cnt[i] = 0;
  endtask

  // Advance the model by one rising edge using the inputs the DUT will sample.
  task automatic model_edge();
    logic [CH-1:0] fire;
    logic [CH-1:0] pos, neg;
    fire = '0;
    for (int i = 0; i < CH; i++) begin
      if (!enable[i]) m_cnt[i] = 0;
      else if (m_s1[i] == m_cond[i]) m_cnt[i] = 0;
      else if (m_cnt[i] == WT - 1) begin
        m_cond[i] = m_s1[i];
        m_cnt[i]  = 0;
        fire[i]   = 1'b1;
      end else m_cnt[i] = m_cnt[i] + 1;
    end
    pos    = fire & m_cond;
    neg    = fire & ~m_cond;
    m_flag = fire | (m_flag & ~clearflags);
    m_s1   = m_s0;
    m_s0   = noisysignal;
    exp_q.push_back({m_cond, pos, neg, m_flag, |fire});
  endtask

  task automatic step();
    logic [EW-1:0] e;
    model_edge();
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL queue: got empty expected one entry at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      check("cond", conditioned, e[4*CH:3*CH+1]);
      check("pos", positiveedge, e[3*CH:2*CH+1]);
      check("neg", negativeedge, e[2*CH:CH+1]);
      check("flag", edgeflag, e[CH:1]);
      check("any", anyedge, e[0]);
    end
    check("pos_neg_excl", positiveedge & negativeedge, 0);
    check("init1_cond", cond1, 2'b11);
    check("init1_pulse", {any1, pos1 | neg1}, 0);
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    rst_n       = 1'b0;
    noisysignal = '0;
    enable      = 4'hF;
    clearflags  = '0;
    ns1         = 2'b11;
    en1         = 2'b11;
    clr1        = 2'b00;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check("rst_cond", conditioned, 0);
    check("rst_pulse", positiveedge | negativeedge, 0);
    check("rst_flag", edgeflag, 0);
    check("rst_any", anyedge, 0);
    check("rst_init1_cond", cond1, 2'b11);
    #2 rst_n = 1'b1;
    repeat (3) step();

    // Rise on channel 0: pulse lands 5 edges after the change.
    noisysignal[0] = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      check("rise_cond", conditioned[0], e >= 5);
      check("rise_pos", positiveedge[0], e == 5);
      check("rise_any", anyedge, e == 5);
    end

    // Two-cycle glitch on channel 1 must be filtered.
    noisysignal[1] = 1'b1;
    step();
    step();
    noisysignal[1] = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      check("glitch_cond", conditioned[1], 0);
      check("glitch_pulse", positiveedge[1] | negativeedge[1], 0);
    end
    check("glitch_flag", edgeflag[1], 0);

    // Sticky flag on channel 2.
    noisysignal[2] = 1'b1;
    repeat (6) step();
    clearflags[2] = 1'b1;
    step();
    clearflags[2] = 1'b0;
    check("flag_pre_clear", edgeflag[2], 0);
    noisysignal[2] = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      step();
      check("fall_neg", negativeedge[2], e == 5);
    end
    check("fall_flag", edgeflag[2], 1);
    repeat (4) step();
    check("flag_sticky", edgeflag[2], 1);
    clearflags[2] = 1'b1;
    step();
    clearflags[2] = 1'b0;
    check("flag_clear", edgeflag[2], 0);
    noisysignal[2] = 1'b1;
    clearflags[2]  = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step();
      check("set_wins", edgeflag[2], e == 5);
    end
    step();
    check("clear_after_set", edgeflag[2], 0);
    clearflags[2] = 1'b0;
    step();

    // Enable gating on channel 3.
    enable[3]      = 1'b0;
    noisysignal[3] = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step();
      check("dis_cond", conditioned[3], 0);
      check("dis_pulse", positiveedge[3] | negativeedge[3], 0);
    end
    enable[3] = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      step();
      check("reen_cond", conditioned[3], e >= WT);
      check("reen_pos", positiveedge[3], e == WT);
    end
    repeat (2) step();

    // All channels toggle together.
    noisysignal = ~noisysignal;
    for (int e = 1; e <= 6; e++) begin
      step();
      check("multi_pulse", positiveedge | negativeedge, (e == 5) ? 4'hF : 4'h0);
      check("multi_any", anyedge, e == 5);
    end

    // Asynchronous reset mid-count on channel 0.
    noisysignal[0] = ~noisysignal[0];
    repeat (3) step();
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_cond", conditioned, 0);
    check("arst_pulse", positiveedge | negativeedge, 0);
    check("arst_flag", edgeflag, 0);
    check("arst_any", anyedge, 0);
    check("arst_init1_cond", cond1, 2'b11);
    @(posedge clk);
    #1;
    check("arst_hold_cond", conditioned, 0);
    check("arst_hold_any", anyedge, 0);
    #2 rst_n = 1'b1;
    repeat (8) step();

    // Random traffic against the model.
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 5) == 0) noisysignal[i] = ~noisysignal[i];
        enable[i]     = ($urandom_range(0, 9) != 0);
        clearflags[i] = ($urandom_range(0, 7) == 0);
      end
      step();
    end
    enable     = 4'hF;
    clearflags = '0;
    repeat (10) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/input_conditioner_bank.md
INPUT_CONDITIONER_BANK -- requirements
Module: input_conditioner_bank

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent input channels, legal range 1..32.
REQ-002 Parameter WAITTIME, default 3: debounce delay in clock cycles, legal range 1..2^COUNTERWIDTH.
REQ-003 Parameter COUNTERWIDTH, default 3: per-channel counter width in bits.
REQ-004 Parameter INIT_LEVEL, default 0: level loaded into the synchronizer flops and into conditioned on reset.
REQ-005 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 Port noisysignal, input, CHANNELS: raw asynchronous inputs, one bit per channel.
REQ-008 Port enable, input, CHANNELS: per-channel debounce enable.
REQ-009 Port clearflags, input, CHANNELS: per-channel sticky-flag clear, sampled synchronously.
REQ-010 Port conditioned, output, CHANNELS: debounced level per channel.
REQ-011 Port positiveedge, output, CHANNELS: one-cycle pulse on a rising transition of conditioned.
REQ-012 Port negativeedge, output, CHANNELS: one-cycle pulse on a falling transition of conditioned.
REQ-013 Port edgeflag, output, CHANNELS: sticky per-channel edge-seen flag.
REQ-014 Port anyedge, output, 1: OR of all positiveedge and negativeedge bits.

Function
REQ-015 Each channel SHALL use a two-flop synchronizer, sync0 then sync1, clocked every cycle regardless of enable.
REQ-016 Debounce rule per channel, evaluated at each edge in priority order:
- enable=0: counter <= 0; conditioned holds; no pulses.
- sync1 == conditioned: counter <= 0.
- counter == WAITTIME-1: conditioned <= sync1; counter <= 0; edge pulse asserted.
- otherwise: counter <= counter+1.
REQ-017 A stable input change first sampled into sync0 at edge k SHALL appear on conditioned after edge k+1+WAITTIME; with WAITTIME=3 that is after edge k+4.
REQ-018 Any cycle in which sync1 equals conditioned SHALL reset the counter, so glitches shorter than WAITTIME cycles in sync1 never reach conditioned.
REQ-019 positiveedge[i] or negativeedge[i] SHALL be registered, asserted in exactly the cycle conditioned[i] first shows its new value, and deasserted on the next edge.
REQ-020 positiveedge[i] and negativeedge[i] SHALL never be high together, and neither SHALL assert without a change on conditioned[i].
REQ-021 edgeflag[i] SHALL set on the edge that raises either pulse of channel i, and clear on an edge with clearflags[i]=1 and no new pulse; when set and clear coincide, set SHALL win.
REQ-022 anyedge SHALL be combinational from the registered pulse outputs, with zero added latency.
REQ-023 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-024 Deasserting enable mid-count SHALL discard progress; after re-enable, debounce restarts from counter 0.
REQ-025 The counter SHALL never exceed WAITTIME-1 and SHALL never wrap.

Reset
REQ-026 While rst_n=0, regardless of clk, the block SHALL force:
- sync0, sync1 and conditioned to INIT_LEVEL on all channels;
- counters to 0;
- positiveedge, negativeedge, edgeflag and anyedge to 0.
REQ-027 Reset asserted mid-debounce SHALL abandon the count without a pulse.
REQ-028 After rst_n rises, the first state update SHALL occur on the next rising clk edge.
REQ-029 No pulse SHALL be generated for input levels that already equal INIT_LEVEL.

Verification
REQ-030 Rise test: CHANNELS=4, WAITTIME=3, enable=4'hF, noisysignal[0] 0->1 held -> conditioned[0]=1 and positiveedge[0] high for exactly 1 cycle, 5 edges after the change; anyedge mirrors it.
REQ-031 Glitch test: noisysignal[1] high for 2 cycles then low -> conditioned[1] stays 0, no pulses, edgeflag[1]=0.
REQ-032 Sticky-flag test: channel 2 falls -> edgeflag[2]=1 and stays set; clearflags[2] pulsed -> 0; clearflags[2] in the same cycle as a new pulse -> edgeflag[2] stays 1.
REQ-033 Enable test: enable[3]=0 during a 10-cycle high on noisysignal[3] -> no change; re-enable with input still high -> conditioned[3]=1 exactly WAITTIME cycles later.
REQ-034 Reset test: rst_n=0 mid-count, asynchronously between clock edges -> outputs cleared immediately; INIT_LEVEL=1 build holding inputs high through reset -> no pulses after release.
REQ-035 Multi-channel test: all four inputs toggle together -> four simultaneous pulses, anyedge high for 1 cycle.
